wb_arbiter_n: RTL and testbench

- Parametrised N-controller Wishbone arbiter. It is the successor to the fixed two-controller (SPI1 + video) arbiter.
- Multiplexes NUM_CTRL Wishbone controllers onto the shared RAM/register/keyboard bus.
- Reserves a periodic time window for the 6502, timed off clk8_en, and asserts cpu_grant_en_o only while the bus is idle.
- Adds round-robin or fixed-priority selection, per-controller ack routing, and an overrun flag.

---
 rtl/wb_arbiter_n_if.sv | 49 ++++
 rtl/wb_arbiter_n.sv | 189 ++++++++++++++++++
 tb/tb_wb_arbiter_n.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_n_if
// Purpose  : Bundles the controller-facing and bus-facing Wishbone signals of
//            the N-controller arbiter.
// Ports    : ctrl_addr_i/ctrl_data_i   flattened controller addr/wdata
//            ctrl_we_i/cycle_i/strobe_i per-controller WE/CYC/STB
//            ctrl_stall_o/ctrl_ack_o   per-controller STALL/ACK
//            wb_addr_o/data_o/we_o/cycle_o/strobe_o  shared bus request
//            wb_stall_i/wb_ack_i       shared bus response
// Modports : master - the arbiter, which masters the shared bus
//            slave  - the environment (controllers plus peripherals)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_n_if #(
  parameter int NUM_CTRL   = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_CTRL*ADDR_WIDTH-1:0] ctrl_addr_i;
  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_data_i;
  logic [NUM_CTRL-1:0]            ctrl_we_i;
  logic [NUM_CTRL-1:0]            ctrl_cycle_i;
  logic [NUM_CTRL-1:0]            ctrl_strobe_i;
  logic [NUM_CTRL-1:0]            ctrl_stall_o;
  logic [NUM_CTRL-1:0]            ctrl_ack_o;
  logic [ADDR_WIDTH-1:0]          wb_addr_o;
  logic [DATA_WIDTH-1:0]          wb_data_o;
  logic                           wb_we_o;
  logic                           wb_cycle_o;
  logic                           wb_strobe_o;
  logic                           wb_stall_i;
  logic                           wb_ack_i;

  modport master (
    input  ctrl_addr_i, ctrl_data_i, ctrl_we_i, ctrl_cycle_i, ctrl_strobe_i,
    input  wb_stall_i, wb_ack_i,
    output ctrl_stall_o, ctrl_ack_o,
    output wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o
  );

  modport slave (
    output ctrl_addr_i, ctrl_data_i, ctrl_we_i, ctrl_cycle_i, ctrl_strobe_i,
    output wb_stall_i, wb_ack_i,
    input  ctrl_stall_o, ctrl_ack_o,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_n
// Purpose  : N-controller Wishbone arbiter sharing the RAM/register/keyboard
//            bus with the 6502. A slot counter advanced by clk8_en reserves
//            the leading CPU_SLOTS slots of every SLOTS-slot period for the
//            CPU; controllers are served round-robin or by fixed priority in
//            the remaining slots, without preemption.
// Ports    : wb_clock_i      system clock (64 MHz)
//            wb_reset_i      asynchronous active-high reset
//            clk8_en_i       single-cycle enable, once every 8 clocks
//            bus             controller/bus signal bundle (master modport)
//            cpu_grant_en_o  CPU owns the bus
//            grant_o         one-hot current controller owner, 0 if none
//            slot_o          current slot index
//            overrun_o       pulse: CPU window opened during a tenure
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_n #(
  parameter int NUM_CTRL      = 2,
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 8,
  parameter int SLOTS         = 8,
  parameter int CPU_SLOTS     = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                       wb_clock_i,
  input  logic                       wb_reset_i,
  input  logic                       clk8_en_i,
  wb_arbiter_n_if.master             bus,
  output logic                       cpu_grant_en_o,
  output logic [NUM_CTRL-1:0]        grant_o,
  output logic [$clog2(SLOTS)-1:0]   slot_o,
  output logic                       overrun_o
);
  localparam int SW    = $clog2(SLOTS);
  localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_CPU  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_valid;
  logic [NUM_CTRL-1:0] grant_nxt;
  logic                cpu_window, pre_window, blocked;

  // --------------------------------------------------------------------------
  // Slot counter and window decode
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      slot_o <= '0;
    end else if (clk8_en_i) begin
      slot_o <= (slot_o == SW'(SLOTS - 1)) ? '0 : slot_o + 1'b1;
    end
  end

  assign cpu_window = (slot_o < SW'(CPU_SLOTS));
  // The slot just before the CPU window is kept free so that no tenure can
  // start that would immediately run into the CPU window.
  assign pre_window = (slot_o == SW'(SLOTS - 1));
  assign blocked    = cpu_window | pre_window;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  if (PRIORITY_MODE == 1) begin : g_fixed
    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = NUM_CTRL - 1; k >= 0; k--) begin
        if (bus.ctrl_cycle_i[k]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(k);
        end
      end
    end
  end else begin : g_rr
    // Offsets are scanned from far to near so the requester closest after
    // the pointer (with wrap) is the last one written and therefore wins.
    always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int off = NUM_CTRL; off >= 1; off--) begin
        if (bus.ctrl_cycle_i[(int'(rr_ptr) + off) % NUM_CTRL]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'((int'(rr_ptr) + off) % NUM_CTRL);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ownership state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state          <= ST_IDLE;
      owner          <= '0;
      rr_ptr         <= IDX_W'(NUM_CTRL - 1);
      grant_o        <= '0;
      cpu_grant_en_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      state          <= state_nxt;
      owner          <= owner_nxt;
      rr_ptr         <= rr_ptr_nxt;
      grant_o        <= grant_nxt;
      cpu_grant_en_o <= (state_nxt == ST_CPU);
      // Slot is about to wrap to 0 while a controller still holds the bus.
      overrun_o      <= clk8_en_i & pre_window & (state == ST_BUS);
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_o;
    case (state)
      ST_IDLE: begin
        if (cpu_window) begin
          state_nxt = ST_CPU;
        end else if (!blocked && win_valid) begin
          state_nxt  = ST_BUS;
          owner_nxt  = win_idx;
          rr_ptr_nxt = win_idx;
          grant_nxt  = NUM_CTRL'(1) << win_idx;
        end
      end
      ST_BUS: begin
        // No preemption: a late tenure defers the CPU until it ends.
        if (!bus.ctrl_cycle_i[owner]) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end
      ST_CPU: begin
        if (!cpu_window) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: owner's request onto the bus, bus response back to the owner
  // --------------------------------------------------------------------------
  always_comb begin
    bus.wb_addr_o   = '0;
    bus.wb_data_o   = '0;
    bus.wb_we_o     = 1'b0;
    bus.wb_cycle_o  = 1'b0;
    bus.wb_strobe_o = 1'b0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (grant_o[k]) begin
        bus.wb_addr_o   = bus.ctrl_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        bus.wb_data_o   = bus.ctrl_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        bus.wb_we_o     = bus.ctrl_we_i[k];
        bus.wb_cycle_o  = bus.ctrl_cycle_i[k];
        bus.wb_strobe_o = bus.ctrl_strobe_i[k];
      end
    end
  end

  assign bus.ctrl_stall_o = ~grant_o | {NUM_CTRL{bus.wb_stall_i}};
  assign bus.ctrl_ack_o   =  grant_o & {NUM_CTRL{bus.wb_ack_i}};

`ifndef SYNTHESIS
  a_cpu_excl : assert property (@(posedge wb_clock_i) disable iff (wb_reset_i)
                                !(cpu_grant_en_o && (|grant_o)));
  a_onehot   : assert property (@(posedge wb_clock_i) disable iff (wb_reset_i)
                                $onehot0(grant_o));
  a_cpu_cyc  : assert property (@(posedge wb_clock_i) disable iff (wb_reset_i)
                                !(cpu_grant_en_o && bus.wb_cycle_o));
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_n
// Purpose  : Directed self-checking bench for wb_arbiter_n. Three instances:
//            u_a (2 controllers, round-robin), u_b (3 controllers,
//            round-robin) and u_c (3 controllers, fixed priority), sharing
//            clock, reset and clk8_en so their slot counters stay aligned.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk8_en = 1'b0;
  logic [2:0] tb_slot;
  int         checks = 0;
  int         failures = 0;

  logic       a_cpu, a_ovr, b_cpu, b_ovr, c_cpu, c_ovr;
  logic [1:0] a_grant;
  logic [2:0] b_grant, c_grant;
  logic [2:0] a_slot, b_slot, c_slot;

  wb_arbiter_n_if #(.NUM_CTRL(2), .ADDR_WIDTH(20), .DATA_WIDTH(8)) bus_a ();
  wb_arbiter_n_if #(.NUM_CTRL(3), .ADDR_WIDTH(20), .DATA_WIDTH(8)) bus_b ();
  wb_arbiter_n_if #(.NUM_CTRL(3), .ADDR_WIDTH(20), .DATA_WIDTH(8)) bus_c ();

  wb_arbiter_n #(.NUM_CTRL(2), .PRIORITY_MODE(0)) u_a (
    .wb_clock_i(clk), .wb_reset_i(rst), .clk8_en_i(clk8_en), .bus(bus_a),
    .cpu_grant_en_o(a_cpu), .grant_o(a_grant), .slot_o(a_slot), .overrun_o(a_ovr));
  wb_arbiter_n #(.NUM_CTRL(3), .PRIORITY_MODE(0)) u_b (
    .wb_clock_i(clk), .wb_reset_i(rst), .clk8_en_i(clk8_en), .bus(bus_b),
    .cpu_grant_en_o(b_cpu), .grant_o(b_grant), .slot_o(b_slot), .overrun_o(b_ovr));
  wb_arbiter_n #(.NUM_CTRL(3), .PRIORITY_MODE(1)) u_c (
    .wb_clock_i(clk), .wb_reset_i(rst), .clk8_en_i(clk8_en), .bus(bus_c),
    .cpu_grant_en_o(c_cpu), .grant_o(c_grant), .slot_o(c_slot), .overrun_o(c_ovr));

  always #5 clk = ~clk;

  // clk8_en: one cycle in eight, changed just after the rising edge.
  initial begin : clk8_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 8;
      clk8_en = (cnt == 0);
    end
  end

  // Reference slot position used to line stimulus up with slot boundaries.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_slot <= 3'd0;
    else if (clk8_en) tb_slot <= tb_slot + 3'd1;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int win_of(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  // Returns at the first falling edge of slot s.
  task automatic wait_slot(input int s);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (clk8_en && int'(tb_slot) == (s + 7) % 8) found = 1'b1;
    end
    if (found) begin
      @(negedge clk);
    end else begin
      checks++; failures++;
      $display("FAIL wait_slot: slot %0d never reached", s);
    end
  endtask

  task automatic test_reset();
    bit e;
    bus_a.ctrl_cycle_i  = 2'b01;
    bus_a.ctrl_strobe_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_grant !== 2'b00 || a_cpu !== 1'b0 || a_slot !== 3'd0 || a_ovr !== 1'b0) begin
        failures++;
        $display("FAIL reset_regs: grant=%b cpu=%b slot=%0d ovr=%b, required 00 0 0 0",
                 a_grant, a_cpu, a_slot, a_ovr);
      end
    end
    checks++;
    if (bus_a.ctrl_stall_o !== 2'b11 || bus_a.ctrl_ack_o !== 2'b00 ||
        bus_a.wb_cycle_o !== 1'b0 || bus_a.wb_strobe_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus: stall=%b ack=%b cyc=%b stb=%b, required 11 00 0 0",
               bus_a.ctrl_stall_o, bus_a.ctrl_ack_o, bus_a.wb_cycle_o, bus_a.wb_strobe_o);
    end
    rst = 1'b0;
    bus_a.ctrl_cycle_i  = 2'b00;
    bus_a.ctrl_strobe_i = 2'b00;
    e = clk8_en;
    @(negedge clk);
    checks++;
    if (a_cpu !== 1'b1 || a_grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_cpu_entry: cpu=%b grant=%b, required 1 00", a_cpu, a_grant);
    end
    if (!e) begin
      for (int i = 0; i < 20 && !e; i++) begin
        if (clk8_en) e = 1'b1;
        else @(negedge clk);
      end
      @(negedge clk);
    end
    checks++;
    if (a_slot !== 3'd1) begin
      failures++;
      $display("FAIL reset_first_slot: slot=%0d, required 1", a_slot);
    end
  endtask

  task automatic test_single_tenure();
    wait_slot(5);
    bus_a.ctrl_addr_i   = {20'hFFFFF, 20'h12345};
    bus_a.ctrl_data_i   = {8'h5A, 8'hA5};
    bus_a.ctrl_we_i     = 2'b01;
    bus_a.ctrl_cycle_i  = 2'b01;
    bus_a.ctrl_strobe_i = 2'b01;
    #1;
    checks++;
    if (bus_a.wb_cycle_o !== 1'b0 || a_slot !== 3'd5) begin
      failures++;
      $display("FAIL single_pre_grant: cyc=%b slot=%0d, required 0 5", bus_a.wb_cycle_o, a_slot);
    end
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: grant=%b, required 01", a_grant);
    end
    checks++;
    if (bus_a.wb_cycle_o !== 1'b1 || bus_a.wb_strobe_o !== 1'b1 || bus_a.wb_we_o !== 1'b1 ||
        bus_a.wb_addr_o !== 20'h12345 || bus_a.wb_data_o !== 8'hA5) begin
      failures++;
      $display("FAIL single_mux: cyc=%b stb=%b we=%b addr=%h data=%h, required 1 1 1 12345 a5",
               bus_a.wb_cycle_o, bus_a.wb_strobe_o, bus_a.wb_we_o, bus_a.wb_addr_o, bus_a.wb_data_o);
    end
    checks++;
    if (bus_a.ctrl_stall_o !== 2'b10) begin
      failures++;
      $display("FAIL single_stall_low: stall=%b, required 10", bus_a.ctrl_stall_o);
    end
    bus_a.wb_stall_i = 1'b1;
    #1;
    checks++;
    if (bus_a.ctrl_stall_o !== 2'b11) begin
      failures++;
      $display("FAIL single_stall_high: stall=%b, required 11", bus_a.ctrl_stall_o);
    end
    bus_a.wb_stall_i = 1'b0;
    @(negedge clk);
    bus_a.wb_ack_i = 1'b1;
    #1;
    checks++;
    if (bus_a.ctrl_ack_o !== 2'b01 || bus_a.ctrl_stall_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL single_ack_route: ack=%b stall1=%b, required 01 1",
               bus_a.ctrl_ack_o, bus_a.ctrl_stall_o[1]);
    end
    @(negedge clk);
    bus_a.wb_ack_i      = 1'b0;
    bus_a.ctrl_cycle_i  = 2'b00;
    bus_a.ctrl_strobe_i = 2'b00;
    #1;
    checks++;
    if (bus_a.wb_cycle_o !== 1'b0 || a_grant !== 2'b01) begin
      failures++;
      $display("FAIL single_drop_cyc: cyc=%b grant=%b, required 0 01", bus_a.wb_cycle_o, a_grant);
    end
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b00 || bus_a.ctrl_stall_o !== 2'b11) begin
      failures++;
      $display("FAIL single_release: grant=%b stall=%b, required 00 11", a_grant, bus_a.ctrl_stall_o);
    end
  endtask

  task automatic test_pre_window();
    int bad_grant, bad_cpu;
    bad_grant = 0;
    bad_cpu   = 0;
    wait_slot(7);
    bus_a.ctrl_cycle_i  = 2'b10;
    bus_a.ctrl_strobe_i = 2'b10;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_grant !== 2'b00) bad_grant++;
      if ((i == 9 || i == 20 || i == 40) && a_cpu !== 1'b1) bad_cpu++;
    end
    checks++;
    if (bad_grant != 0) begin
      failures++;
      $display("FAIL pre_no_grant: %0d cycles granted, required 0", bad_grant);
    end
    checks++;
    if (bad_cpu != 0 || a_slot !== 3'd4) begin
      failures++;
      $display("FAIL pre_cpu_hold: cpu misses=%0d slot=%0d, required 0 4", bad_cpu, a_slot);
    end
    @(negedge clk);
    checks++;
    if (a_cpu !== 1'b0) begin
      failures++;
      $display("FAIL pre_cpu_release: cpu=%b, required 0", a_cpu);
    end
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b10 || bus_a.wb_addr_o !== 20'hFFFFF) begin
      failures++;
      $display("FAIL pre_late_grant: grant=%b addr=%h, required 10 fffff", a_grant, bus_a.wb_addr_o);
    end
    bus_a.ctrl_cycle_i  = 2'b00;
    bus_a.ctrl_strobe_i = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int pulses, pulse_at, conc, cpu_held;
    pulses = 0; pulse_at = -1; conc = 0; cpu_held = 0;
    wait_slot(6);
    bus_a.ctrl_cycle_i  = 2'b01;
    bus_a.ctrl_strobe_i = 2'b01;
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b01) begin
      failures++;
      $display("FAIL ovr_grant: grant=%b, required 01", a_grant);
    end
    for (int i = 2; i <= 24; i++) begin
      @(negedge clk);
      if (a_ovr === 1'b1) begin pulses++; pulse_at = i; end
      if (a_cpu !== 1'b0) cpu_held++;
    end
    checks++;
    if (a_slot !== 3'd1 || a_grant !== 2'b01) begin
      failures++;
      $display("FAIL ovr_hold: slot=%0d grant=%b, required 1 01", a_slot, a_grant);
    end
    bus_a.ctrl_cycle_i  = 2'b00;
    bus_a.ctrl_strobe_i = 2'b00;
    @(negedge clk);
    if (a_ovr === 1'b1) pulses++;
    if (a_cpu === 1'b1 && a_grant !== 2'b00) conc++;
    checks++;
    if (a_grant !== 2'b00 || a_cpu !== 1'b0) begin
      failures++;
      $display("FAIL ovr_release: grant=%b cpu=%b, required 00 0", a_grant, a_cpu);
    end
    @(negedge clk);
    if (a_ovr === 1'b1) pulses++;
    if (a_cpu === 1'b1 && a_grant !== 2'b00) conc++;
    checks++;
    if (a_cpu !== 1'b1) begin
      failures++;
      $display("FAIL ovr_cpu_late: cpu=%b, required 1", a_cpu);
    end
    checks++;
    if (pulses != 1 || pulse_at != 16) begin
      failures++;
      $display("FAIL ovr_pulse: pulses=%0d at cycle %0d, required 1 at 16", pulses, pulse_at);
    end
    checks++;
    if (cpu_held != 0 || conc != 0) begin
      failures++;
      $display("FAIL ovr_cpu_excl: cpu during tenure=%0d concurrent=%0d, required 0 0", cpu_held, conc);
    end
  endtask

  task automatic test_round_robin();
    int n, w;
    n = 0;
    wait_slot(4);
    bus_b.ctrl_addr_i   = {20'hA0002, 20'hA0001, 20'hA0000};
    bus_b.ctrl_cycle_i  = 3'b111;
    bus_b.ctrl_strobe_i = 3'b111;
    for (int c = 0; c < 300 && n < 4; c++) begin
      @(negedge clk);
      if (b_grant !== 3'b000) begin
        w = win_of(b_grant);
        checks++;
        if (w != n % 3 || bus_b.wb_addr_o !== 20'hA0000 + 20'(n % 3)) begin
          failures++;
          $display("FAIL rr_order: tenure %0d grant=%b addr=%h, required controller %0d",
                   n, b_grant, bus_b.wb_addr_o, n % 3);
        end
        @(negedge clk);
        if (w < 3) bus_b.ctrl_cycle_i[w] = 1'b0;
        @(negedge clk);
        checks++;
        if (b_grant !== 3'b000) begin
          failures++;
          $display("FAIL rr_idle_gap: grant=%b, required 000", b_grant);
        end
        if (w < 3) bus_b.ctrl_cycle_i[w] = 1'b1;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_count: tenures=%0d, required 4", n);
    end
    bus_b.ctrl_cycle_i  = 3'b000;
    bus_b.ctrl_strobe_i = 3'b000;
  endtask

  task automatic test_fixed_priority();
    int n, w;
    n = 0;
    wait_slot(4);
    bus_c.ctrl_addr_i   = {20'hB0002, 20'hB0001, 20'hB0000};
    bus_c.ctrl_cycle_i  = 3'b111;
    bus_c.ctrl_strobe_i = 3'b111;
    for (int c = 0; c < 300 && n < 4; c++) begin
      @(negedge clk);
      if (c_grant !== 3'b000) begin
        w = win_of(c_grant);
        checks++;
        if (w != 0 || bus_c.wb_addr_o !== 20'hB0000) begin
          failures++;
          $display("FAIL fp_order: tenure %0d grant=%b addr=%h, required controller 0",
                   n, c_grant, bus_c.wb_addr_o);
        end
        @(negedge clk);
        if (w < 3) bus_c.ctrl_cycle_i[w] = 1'b0;
        @(negedge clk);
        if (w < 3) bus_c.ctrl_cycle_i[w] = 1'b1;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL fp_count: tenures=%0d, required 4", n);
    end
    bus_c.ctrl_cycle_i  = 3'b000;
    bus_c.ctrl_strobe_i = 3'b000;
  endtask

  task automatic test_reset_mid_tenure();
    wait_slot(5);
    bus_a.ctrl_cycle_i  = 2'b01;
    bus_a.ctrl_strobe_i = 2'b01;
    @(negedge clk);
    checks++;
    if (bus_a.wb_cycle_o !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: cyc=%b, required 1", bus_a.wb_cycle_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.wb_cycle_o !== 1'b0 || a_grant !== 2'b00 || bus_a.ctrl_stall_o !== 2'b11) begin
      failures++;
      $display("FAIL midrst_async: cyc=%b grant=%b stall=%b, required 0 00 11",
               bus_a.wb_cycle_o, a_grant, bus_a.ctrl_stall_o);
    end
    @(negedge clk);
    @(negedge clk);
    bus_a.ctrl_cycle_i  = 2'b00;
    bus_a.ctrl_strobe_i = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cpu !== 1'b1 || a_slot !== 3'd0) begin
      failures++;
      $display("FAIL midrst_recover: cpu=%b slot=%0d, required 1 0", a_cpu, a_slot);
    end
  endtask

  initial begin
    bus_a.ctrl_addr_i = '0; bus_a.ctrl_data_i = '0; bus_a.ctrl_we_i = '0;
    bus_a.ctrl_cycle_i = '0; bus_a.ctrl_strobe_i = '0;
    bus_a.wb_stall_i = 1'b0; bus_a.wb_ack_i = 1'b0;
    bus_b.ctrl_addr_i = '0; bus_b.ctrl_data_i = '0; bus_b.ctrl_we_i = '0;
    bus_b.ctrl_cycle_i = '0; bus_b.ctrl_strobe_i = '0;
    bus_b.wb_stall_i = 1'b0; bus_b.wb_ack_i = 1'b0;
    bus_c.ctrl_addr_i = '0; bus_c.ctrl_data_i = '0; bus_c.ctrl_we_i = '0;
    bus_c.ctrl_cycle_i = '0; bus_c.ctrl_strobe_i = '0;
    bus_c.wb_stall_i = 1'b0; bus_c.wb_ack_i = 1'b0;

    test_reset();
    test_single_tenure();
    test_pre_window();
    test_overrun();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_tenure();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
